// File: rtl/cam_ctrl.sv
// cam_ctrl: command sequencer for a 16-entry CAM.
// Arbitrates between write and search requesters and drives the CAM pins.
// The CAM has no valid bits, so this block mirrors its write pointer and
// keeps a valid mask that qualifies the raw match vector.
module cam_ctrl #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MATCH_LAT = 1,
  localparam int unsigned IDXW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             srch_valid,
  output logic             srch_ready,
  input  logic [WIDTH-1:0] srch_key,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic             res_multi,
  output logic [IDXW-1:0]  res_index,
  input  logic             clr_req,
  output logic [IDXW:0]    occupancy,
  output logic             full,
  output logic             busy,
  output logic             cam_we,
  output logic [WIDTH-1:0] cam_content,
  output logic             cam_rst_n,
  input  logic [DEPTH-1:0] cam_found
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrite  = 3'd1;
  localparam logic [2:0] StSrch   = 3'd2;
  localparam logic [2:0] StCapt   = 3'd3;
  localparam logic [2:0] StResult = 3'd4;
  localparam logic [2:0] StClear  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             rr_srch_q, rr_srch_d;   // 1: last grant went to search
  logic [WIDTH-1:0] content_q, content_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [IDXW-1:0]  wp_q, wp_d;
  logic [IDXW:0]    occ_q, occ_d;
  logic             clr_pend_q, clr_pend_d;
  logic [7:0]       lat_q, lat_d;
  logic             res_hit_q, res_hit_d;
  logic             res_multi_q, res_multi_d;
  logic [IDXW-1:0]  res_index_q, res_index_d;

  logic             idle_grant;
  logic             wr_acc, srch_acc;
  logic [DEPTH-1:0] match;
  logic             hit_c, multi_c;
  logic [IDXW-1:0]  idx_c;

  // Readies: only in IDLE with no clear pending; a tie goes opposite the last grant.
  always_comb begin
    idle_grant = (state_q == StIdle) && !clr_pend_q && !rst;
    wr_ready   = idle_grant && (!srch_valid || rr_srch_q);
    srch_ready = idle_grant && (!wr_valid || !rr_srch_q);
    wr_acc     = wr_valid && wr_ready;
    srch_acc   = srch_valid && srch_ready;
  end

  // Qualify raw CAM matches with the valid mask and encode hit/multi/lowest index.
  always_comb begin
    match   = cam_found & valid_q;
    hit_c   = |match;
    multi_c = |(match & (match - DEPTH'(1)));
    idx_c   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) idx_c = IDXW'(i);
    end
  end

  // Next-state logic for the sequencer and mirrored CAM bookkeeping.
  always_comb begin
    state_d     = state_q;
    rr_srch_d   = rr_srch_q;
    content_d   = content_q;
    valid_d     = valid_q;
    wp_d        = wp_q;
    occ_d       = occ_q;
    lat_d       = lat_q;
    res_hit_d   = res_hit_q;
    res_multi_d = res_multi_q;
    res_index_d = res_index_q;
    clr_pend_d  = clr_pend_q | clr_req;
    case (state_q)
      StIdle: begin
        if (clr_pend_q) begin
          state_d = StClear;
        end else if (wr_acc) begin
          state_d   = StWrite;
          content_d = wr_data;
          rr_srch_d = 1'b0;
        end else if (srch_acc) begin
          state_d   = StSrch;
          content_d = srch_key;
          rr_srch_d = 1'b1;
          lat_d     = '0;
        end
      end
      StWrite: begin
        // The CAM advances its one-hot pointer on every write; track it here.
        valid_d[wp_q] = 1'b1;
        wp_d = (wp_q == IDXW'(DEPTH - 1)) ? '0 : wp_q + IDXW'(1);
        if (occ_q != (IDXW + 1)'(DEPTH)) occ_d = occ_q + (IDXW + 1)'(1);
        state_d = StIdle;
      end
      StSrch: begin
        if (lat_q == 8'(MATCH_LAT - 1)) state_d = StCapt;
        else lat_d = lat_q + 8'd1;
      end
      StCapt: begin
        res_hit_d   = hit_c;
        res_multi_d = multi_c;
        res_index_d = idx_c;
        state_d     = StResult;
      end
      StResult: begin
        if (res_ready) state_d = StIdle;
      end
      StClear: begin
        valid_d    = '0;
        wp_d       = '0;
        occ_d      = '0;
        // A request arriving during the clear itself is kept for another pass.
        clr_pend_d = clr_req;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_srch_q   <= 1'b1;
      content_q   <= '0;
      valid_q     <= '0;
      wp_q        <= '0;
      occ_q       <= '0;
      clr_pend_q  <= 1'b0;
      lat_q       <= '0;
      res_hit_q   <= 1'b0;
      res_multi_q <= 1'b0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_srch_q   <= rr_srch_d;
      content_q   <= content_d;
      valid_q     <= valid_d;
      wp_q        <= wp_d;
      occ_q       <= occ_d;
      clr_pend_q  <= clr_pend_d;
      lat_q       <= lat_d;
      res_hit_q   <= res_hit_d;
      res_multi_q <= res_multi_d;
      res_index_q <= res_index_d;
    end
  end

  // Output decode.
  always_comb begin
    res_valid   = (state_q == StResult);
    res_hit     = res_hit_q;
    res_multi   = res_multi_q;
    res_index   = res_index_q;
    occupancy   = occ_q;
    full        = (occ_q == (IDXW + 1)'(DEPTH));
    busy        = (state_q != StIdle) || clr_pend_q;
    cam_we      = (state_q == StWrite);
    cam_content = content_q;
    cam_rst_n   = ~(rst | (state_q == StClear));
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: self-checking bench for cam_ctrl with a behavioural CAM and a
// reference model that tracks stored words by write order.
module tb_cam_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0, srch_valid = 1'b0, res_ready = 1'b1, clr_req = 1'b0;
  logic [6:0]  wr_data = '0, srch_key = '0;
  logic        wr_ready, srch_ready, res_valid, res_hit, res_multi, full, busy;
  logic [3:0]  res_index;
  logic [4:0]  occupancy;
  logic        cam_we, cam_rst_n;
  logic [6:0]  cam_content;
  logic [15:0] cam_found;

  int n_cmp = 0;
  int n_err = 0;

  cam_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_multi(res_multi), .res_index(res_index),
    .clr_req(clr_req), .occupancy(occupancy), .full(full), .busy(busy),
    .cam_we(cam_we), .cam_content(cam_content), .cam_rst_n(cam_rst_n),
    .cam_found(cam_found)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: one-hot write pointer, zeroed on reset, one-cycle match latency.
  logic [6:0] cam_mem [16];
  int         cam_ptr;
  always @(posedge clk) begin
    if (!cam_rst_n) begin
      for (int i = 0; i < 16; i++) cam_mem[i] <= '0;
      cam_ptr <= 0;
    end else if (cam_we) begin
      cam_mem[cam_ptr] <= cam_content;
      cam_ptr <= (cam_ptr + 1) % 16;
    end
    for (int i = 0; i < 16; i++) cam_found[i] <= (cam_mem[i] == cam_content);
  end

  // Reference model: the n-th write since a clear lands in slot n mod 16.
  logic [6:0] m_word [16];
  bit         m_valid [16];
  int         m_wcnt, m_occ;

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_wcnt = 0;
    m_occ  = 0;
  endfunction

  function automatic void model_write(input logic [6:0] d);
    m_word[m_wcnt % 16]  = d;
    m_valid[m_wcnt % 16] = 1'b1;
    m_wcnt++;
    if (m_occ < 16) m_occ++;
  endfunction

  function automatic void model_search(input logic [6:0] key, output logic hit,
                                       output logic multi, output logic [3:0] idx);
    int n = 0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_word[i] == key) begin
        if (n == 0) idx = 4'(i);
        n++;
      end
    end
    hit   = (n > 0);
    multi = (n > 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; wr_valid = 1'b0; srch_valid = 1'b0; clr_req = 1'b0; res_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    model_clear();
  endtask

  // Issue one write; reports acceptance and the CAM pins seen in the cycle after accept.
  task automatic do_write(input logic [6:0] d, output bit ok, output logic we_seen,
                          output logic [6:0] content_seen);
    ok = 1'b0; we_seen = 1'b0; content_seen = '0;
    wr_valid = 1'b1; wr_data = d;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready) begin ok = 1'b1; break; end
      step();
    end
    if (ok) begin
      step();
      wr_valid = 1'b0;
      we_seen = cam_we;
      content_seen = cam_content;
      model_write(d);
      step();
    end
    wr_valid = 1'b0;
  endtask

  // Issue one search; lat counts clock edges from accept to res_valid.
  task automatic do_search(input logic [6:0] key, output bit ok, output logic hit,
                           output logic multi, output logic [3:0] idx, output int lat);
    ok = 1'b0; hit = 1'b0; multi = 1'b0; idx = '0; lat = 0;
    srch_valid = 1'b1; srch_key = key;
    for (int i = 0; i < 20; i++) begin
      if (srch_ready) begin ok = 1'b1; break; end
      step();
    end
    if (ok) begin
      step();
      srch_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 20) begin step(); lat++; end
      ok = res_valid;
      hit = res_hit; multi = res_multi; idx = res_index;
      if (res_ready) step();
    end
    srch_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok; logic h, m; logic [3:0] ix; int lat;
    rst = 1'b1;
    step(); step();
    n_cmp++; if (cam_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_cam_rst_n: got %0b want 0", cam_rst_n); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %0b want 0", res_valid); end
    n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (busy !== 1'b0 || full !== 1'b0 || cam_we !== 1'b0) begin
      n_err++; $display("FAIL rst_flags: busy=%0b full=%0b we=%0b want 0 0 0", busy, full, cam_we); end
    rst = 1'b0;
    step();
    model_clear();
    n_cmp++; if (cam_rst_n !== 1'b1) begin n_err++; $display("FAIL rst_release: got %0b want 1", cam_rst_n); end
    do_search(7'h00, ok, h, m, ix, lat);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_srch_timeout: got 0 want 1"); end
    n_cmp++; if (h !== 1'b0 || ix !== 4'd0 || m !== 1'b0) begin
      n_err++; $display("FAIL rst_srch0: hit=%0b multi=%0b idx=%0d want 0 0 0", h, m, ix); end
  endtask

  task automatic test_basic();
    bit ok; logic we; logic [6:0] c; logic h, m; logic [3:0] ix; int lat;
    logic [6:0] words [3];
    words[0] = 7'h11; words[1] = 7'h22; words[2] = 7'h33;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_write(words[i], ok, we, c);
      n_cmp++; if (!ok || we !== 1'b1 || c !== words[i]) begin
        n_err++; $display("FAIL basic_write%0d: ok=%0b we=%0b content=%h want 1 1 %h", i, ok, we, c, words[i]); end
    end
    do_search(7'h22, ok, h, m, ix, lat);
    n_cmp++; if (!ok || h !== 1'b1 || m !== 1'b0 || ix !== 4'd1) begin
      n_err++; $display("FAIL basic_srch: ok=%0b hit=%0b multi=%0b idx=%0d want 1 1 0 1", ok, h, m, ix); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_lat: got %0d want 3", lat); end
    n_cmp++; if (occupancy !== 5'd3) begin n_err++; $display("FAIL basic_occ: got %0d want 3", occupancy); end
  endtask

  task automatic test_multi();
    bit ok; logic we; logic [6:0] c; logic h, m; logic [3:0] ix; int lat;
    apply_reset();
    do_write(7'h05, ok, we, c);
    do_write(7'h09, ok, we, c);
    do_write(7'h05, ok, we, c);
    do_search(7'h05, ok, h, m, ix, lat);
    n_cmp++; if (!ok || h !== 1'b1 || m !== 1'b1 || ix !== 4'd0) begin
      n_err++; $display("FAIL multi_srch: ok=%0b hit=%0b multi=%0b idx=%0d want 1 1 1 0", ok, h, m, ix); end
  endtask

  task automatic test_wrap();
    bit ok; logic we; logic [6:0] c; logic h, m; logic [3:0] ix; int lat;
    apply_reset();
    for (int i = 0; i < 17; i++) do_write(7'(8'h40 + i), ok, we, c);
    n_cmp++; if (full !== 1'b1 || occupancy !== 5'd16) begin
      n_err++; $display("FAIL wrap_full: full=%0b occ=%0d want 1 16", full, occupancy); end
    do_search(7'h40, ok, h, m, ix, lat);
    n_cmp++; if (!ok || h !== 1'b0 || ix !== 4'd0) begin
      n_err++; $display("FAIL wrap_old: ok=%0b hit=%0b idx=%0d want 1 0 0", ok, h, ix); end
    do_search(7'h50, ok, h, m, ix, lat);
    n_cmp++; if (!ok || h !== 1'b1 || ix !== 4'd0) begin
      n_err++; $display("FAIL wrap_new: ok=%0b hit=%0b idx=%0d want 1 1 0", ok, h, ix); end
  endtask

  task automatic test_random();
    bit ok; logic we; logic [6:0] c, k; logic h, m, eh, em; logic [3:0] ix, eix; int lat, r;
    apply_reset();
    for (int op = 0; op < 80; op++) begin
      r = $urandom_range(0, 19);
      k = 7'($urandom_range(0, 7));
      if (r == 0) begin
        clr_req = 1'b1; step(); clr_req = 1'b0;
        for (int i = 0; i < 10 && busy; i++) step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_clr_busy: got %0b want 0", busy); end
        model_clear();
      end else if (r < 10) begin
        do_write(k, ok, we, c);
        n_cmp++; if (!ok || we !== 1'b1 || c !== k) begin
          n_err++; $display("FAIL rnd_write: ok=%0b we=%0b content=%h want 1 1 %h", ok, we, c, k); end
      end else begin
        model_search(k, eh, em, eix);
        do_search(k, ok, h, m, ix, lat);
        n_cmp++; if (!ok || lat !== 3 || h !== eh || m !== em || ix !== eix) begin
          n_err++; $display("FAIL rnd_srch key=%h: ok=%0b lat=%0d hit=%0b multi=%0b idx=%0d want 1 3 %0b %0b %0d",
                            k, ok, lat, h, m, ix, eh, em, eix); end
      end
      n_cmp++; if (occupancy !== 5'(m_occ) || full !== (m_occ == 16)) begin
        n_err++; $display("FAIL rnd_occ: occ=%0d full=%0b want %0d %0b", occupancy, full, m_occ, m_occ == 16); end
    end
  endtask

  task automatic test_back_to_back();
    int g[$];
    logic h, m, eh, em; logic [3:0] ix, eix;
    apply_reset();
    wr_valid = 1'b1; srch_valid = 1'b1; wr_data = 7'h2A; srch_key = 7'h2A;
    for (int cyc = 0; cyc < 60 && g.size() < 4; cyc++) begin
      if (wr_valid && wr_ready) begin g.push_back(0); model_write(wr_data); end
      else if (srch_valid && srch_ready) g.push_back(1);
      step();
      if (g.size() == 4) begin wr_valid = 1'b0; srch_valid = 1'b0; end
    end
    wr_valid = 1'b0; srch_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) step();
    n_cmp++; if (g.size() !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", g.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (g[i] !== (i % 2)) begin
          n_err++; $display("FAIL b2b_grant%0d: got %0d want %0d (0=W 1=S)", i, g[i], i % 2); end
      end
    end
    // Held result: res_ready low for 5 cycles with a write waiting.
    res_ready = 1'b0; srch_valid = 1'b1; srch_key = 7'h2A;
    for (int i = 0; i < 20 && !srch_ready; i++) step();
    step();
    srch_valid = 1'b0; wr_valid = 1'b1; wr_data = 7'h7F;
    for (int i = 0; i < 20 && !res_valid; i++) step();
    model_search(7'h2A, eh, em, eix);
    h = res_hit; m = res_multi; ix = res_index;
    n_cmp++; if (res_valid !== 1'b1 || h !== eh || m !== em || ix !== eix) begin
      n_err++; $display("FAIL hold_first: valid=%0b hit=%0b multi=%0b idx=%0d want 1 %0b %0b %0d",
                        res_valid, h, m, ix, eh, em, eix); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (res_valid !== 1'b1 || res_hit !== h || res_multi !== m || res_index !== ix || wr_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_cyc%0d: valid=%0b hit=%0b multi=%0b idx=%0d wr_ready=%0b want 1 %0b %0b %0d 0",
                          k, res_valid, res_hit, res_multi, res_index, wr_ready, h, m, ix); end
    end
    wr_valid = 1'b0; res_ready = 1'b1;
    step();
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %0b want 0", res_valid); end
  endtask

  task automatic test_clear();
    bit ok; logic we; logic [6:0] c; logic h, m; logic [3:0] ix; int lat, lows;
    apply_reset();
    do_write(7'h11, ok, we, c);
    do_write(7'h22, ok, we, c);
    res_ready = 1'b0; srch_valid = 1'b1; srch_key = 7'h22;
    for (int i = 0; i < 20 && !srch_ready; i++) step();
    step();
    srch_valid = 1'b0;
    for (int i = 0; i < 20 && !res_valid; i++) step();
    clr_req = 1'b1; step(); clr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (res_valid !== 1'b1 || cam_rst_n !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL clr_held%0d: valid=%0b cam_rst_n=%0b busy=%0b want 1 1 1", k, res_valid, cam_rst_n, busy); end
      step();
    end
    res_ready = 1'b1;
    step();
    n_cmp++; if (res_valid !== 1'b0 || cam_rst_n !== 1'b1) begin
      n_err++; $display("FAIL clr_handshake: valid=%0b cam_rst_n=%0b want 0 1", res_valid, cam_rst_n); end
    lows = 0;
    for (int k = 0; k < 5; k++) begin step(); if (!cam_rst_n) lows++; end
    model_clear();
    n_cmp++; if (lows !== 1) begin n_err++; $display("FAIL clr_pulse: got %0d low cycles want 1", lows); end
    n_cmp++; if (occupancy !== 5'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL clr_occ: occ=%0d busy=%0b want 0 0", occupancy, busy); end
    do_search(7'h22, ok, h, m, ix, lat);
    n_cmp++; if (!ok || h !== 1'b0) begin n_err++; $display("FAIL clr_srch: ok=%0b hit=%0b want 1 0", ok, h); end
    // Reset in the middle of a search drops it.
    do_write(7'h33, ok, we, c);
    srch_valid = 1'b1; srch_key = 7'h33;
    for (int i = 0; i < 20 && !srch_ready; i++) step();
    step();
    srch_valid = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++; if (cam_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_pin: got %0b want 0", cam_rst_n); end
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0 || occupancy !== 5'd0) begin
        n_err++; $display("FAIL rst_mid%0d: valid=%0b busy=%0b occ=%0d want 0 0 0", k, res_valid, busy, occupancy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
